tetris_key_cmd: RTL and testbench

//  Consumes keycode_export[15:0] from nios_system: two USB HID keycodes, slot0=[7:0], slot1=[15:8], 0x00=empty.

---
 rtl/tetris_key_cmd.sv | 204 ++++++++++++++++++++
 tb/tb_tetris_key_cmd.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_key_cmd.sv
// Keyboard-to-command front end for the Tetris game FSM: decodes two HID slots, detects presses,
// applies DAS/ARR auto-repeat and issues one command per handshake. Optional filter: KEY_DEBOUNCE_EN.
module tetris_key_cmd #(
  parameter int DAS_CYCLES      = 8_000_000,
  parameter int ARR_CYCLES      = 2_500_000,
  parameter int DEBOUNCE_CYCLES = 50_000
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [15:0] keycode,
  output logic        cmd_valid,
  output logic [2:0]  cmd_code,
  input  logic        cmd_ready
);

  localparam int CNT_MAX = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DAS_LOAD = CNT_W'(DAS_CYCLES - 2);
  localparam logic [CNT_W-1:0] ARR_LOAD = CNT_W'(ARR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] C_NONE   = 3'd0;
  localparam logic [2:0] C_LEFT   = 3'd1;
  localparam logic [2:0] C_RIGHT  = 3'd2;
  localparam logic [2:0] C_ROTATE = 3'd3;
  localparam logic [2:0] C_SOFT   = 3'd4;
  localparam logic [2:0] C_HARD   = 3'd5;

  if (DAS_CYCLES < 2 || ARR_CYCLES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("tetris_key_cmd: DAS_CYCLES and ARR_CYCLES must be >= 2, DEBOUNCE_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } rep_state_t;

  // Held-key vector is indexed by command code, so bit k means "command k".
  function automatic logic [5:1] f_decode(input logic [15:0] kc);
    logic [5:1] h;
    h[1] = (kc[7:0] == 8'h04) || (kc[15:8] == 8'h04);
    h[2] = (kc[7:0] == 8'h07) || (kc[15:8] == 8'h07);
    h[3] = (kc[7:0] == 8'h1A) || (kc[15:8] == 8'h1A);
    h[4] = (kc[7:0] == 8'h16) || (kc[15:8] == 8'h16);
    h[5] = (kc[7:0] == 8'h2C) || (kc[15:8] == 8'h2C);
    return h;
  endfunction

  function automatic logic [2:0] f_rep_key(input logic [5:1] h);
    logic [2:0] k;
    if (h[1] && !h[2])      k = C_LEFT;
    else if (h[2] && !h[1]) k = C_RIGHT;
    else if (h[4])          k = C_SOFT;
    else                    k = C_NONE;
    return k;
  endfunction

  function automatic logic [5:1] f_onehot(input logic [2:0] code);
    logic [5:1] v;
    v = '0;
    case (code)
      C_LEFT:   v[1] = 1'b1;
      C_RIGHT:  v[2] = 1'b1;
      C_ROTATE: v[3] = 1'b1;
      C_SOFT:   v[4] = 1'b1;
      C_HARD:   v[5] = 1'b1;
      default:  v    = '0;
    endcase
    return v;
  endfunction

  function automatic logic [2:0] f_pick(input logic [5:1] c);
    logic [2:0] k;
    if (c[5])      k = C_HARD;
    else if (c[3]) k = C_ROTATE;
    else if (c[1]) k = C_LEFT;
    else if (c[2]) k = C_RIGHT;
    else if (c[4]) k = C_SOFT;
    else           k = C_NONE;
    return k;
  endfunction

  // Stage p0: keycode sample register
  logic [15:0] r_kc_p0;
  logic [15:0] w_kc_p0;

  always_ff @(posedge clk_clk) begin
    r_kc_p0 <= keycode;
  end

`ifdef KEY_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  logic [15:0]     r_kc_q;
  logic [DB_W-1:0] r_db_cnt;

  // The count only runs while the sampled code differs from the accepted one and stays put.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_kc_q   <= '0;
      r_db_cnt <= '0;
    end else if (keycode != r_kc_p0) begin
      r_db_cnt <= '0;
    end else if (r_kc_p0 != r_kc_q) begin
      if (r_db_cnt == DB_LAST) begin
        r_kc_q   <= r_kc_p0;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_ONE;
      end
    end
  end

  assign w_kc_p0 = r_kc_q;
`else
  assign w_kc_p0 = r_kc_p0;
`endif

  // Stage p1: decode, press detection and auto-repeat
  logic [5:1]       r_key_prev;
  logic [5:1]       w_held;
  logic [5:1]       w_press;
  logic [2:0]       w_rk;
  rep_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_rk_q, w_rk_nxt;
  logic [2:0]       w_rep_code;

  assign w_held  = f_decode(w_kc_p0);
  assign w_press = w_held & ~r_key_prev;
  // Repeat key follows the registered held set so the first repeat lands DAS edges after the press.
  assign w_rk    = f_rep_key(r_key_prev);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rk_nxt    = r_rk_q;
    w_rep_code  = C_NONE;
    case (r_state)
      S_IDLE: begin
        if (w_rk != C_NONE) begin
          w_state_nxt = S_DELAY;
          w_cnt_nxt   = DAS_LOAD;
          w_rk_nxt    = w_rk;
        end
      end
      S_DELAY, S_REPEAT: begin
        if (w_rk != r_rk_q) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_REPEAT;
          w_cnt_nxt   = ARR_LOAD;
          w_rep_code  = r_rk_q;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_ONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stage p2: pending set and output register
  logic [5:1] r_pend;
  logic       r_cmd_valid;
  logic [2:0] r_cmd_code;
  logic [5:1] w_comb;
  logic [2:0] w_sel_code;
  logic       w_load;

  assign w_comb     = r_pend | w_press | f_onehot(w_rep_code);
  assign w_sel_code = f_pick(w_comb);
  assign w_load     = !r_cmd_valid || cmd_ready;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_key_prev  <= '0;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rk_q      <= C_NONE;
      r_pend      <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= C_NONE;
    end else begin
      r_key_prev <= w_held;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rk_q     <= w_rk_nxt;
      if (w_load) begin
        r_cmd_valid <= |w_comb;
        r_cmd_code  <= w_sel_code;
        r_pend      <= w_comb & ~f_onehot(w_sel_code);
      end else begin
        r_pend      <= w_comb;
      end
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_code  = r_cmd_code;

endmodule

// File: tb/tb_tetris_key_cmd.sv
// Bench for tetris_key_cmd: directed vector table, timed repeat/reset sequences and random
// keycode traffic checked every cycle against an event-schedule reference model.
module tb_tetris_key_cmd;
  localparam int DAS = 10;
  localparam int ARR = 4;
  localparam int DB  = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] kc;
  logic        rdy;
  logic        valid;
  logic [2:0]  code;

  always #5 clk = ~clk;

  tetris_key_cmd #(
    .DAS_CYCLES(DAS),
    .ARR_CYCLES(ARR),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk_clk(clk),
    .reset_reset(rst),
    .keycode(kc),
    .cmd_valid(valid),
    .cmd_code(code),
    .cmd_ready(rdy)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  task automatic check(input string name, input logic v, input logic [2:0] c,
                       input logic ev, input logic [2:0] ec);
    n_checks++;
    if (v !== ev || c !== ec) begin
      n_errors++;
      $display("FAIL %s @%0t: got valid=%0b code=%0d, expected valid=%0b code=%0d",
               name, $time, v, c, ev, ec);
    end
  endtask

  // Reference model: commands are bits 1..5; auto-repeat is an absolute-time schedule.
  localparam logic [7:0] KEYS [1:5] = '{8'h04, 8'h07, 8'h1A, 8'h16, 8'h2C};
  int          prio [5] = '{5, 3, 1, 2, 4};
  bit          m_kp   [1:5];
  bit          m_pend [1:5];
  bit          m_valid = 0;
  logic [2:0]  m_code  = 3'd0;
  bit          m_busy  = 0;
  int          m_bkey  = 0;
  int          m_next  = 0;
  int          m_edge  = 0;
  logic [15:0] m_rkc   = 16'h0;
  logic [15:0] m_kcq   = 16'h0;
  logic [15:0] hk [64];
  bit          hr [64];

  always @(posedge clk) begin : model
    bit          held [1:5];
    bit          ev   [1:5];
    bit          comb [1:5];
    logic [15:0] eff;
    int          rk;
    int          pick;
    bit          ok;
    hk[m_edge % 64] = kc;
    hr[m_edge % 64] = rst;
    if (rst) begin
      for (int k = 1; k <= 5; k++) begin
        m_kp[k]   = 0;
        m_pend[k] = 0;
      end
      m_valid = 0;
      m_code  = 3'd0;
      m_busy  = 0;
      m_kcq   = 16'h0;
    end else begin
`ifdef KEY_DEBOUNCE_EN
      eff = m_kcq;
`else
      eff = m_rkc;
`endif
      for (int k = 1; k <= 5; k++) begin
        held[k] = (eff[7:0] == KEYS[k]) || (eff[15:8] == KEYS[k]);
        ev[k]   = held[k] && !m_kp[k];
      end
      rk = 0;
      if (m_kp[1] != m_kp[2]) rk = m_kp[1] ? 1 : 2;
      else if (m_kp[4])       rk = 4;
      if (m_busy) begin
        if (rk != m_bkey) m_busy = 0;
        else if (m_edge == m_next) begin
          ev[m_bkey] = 1;
          m_next     = m_edge + ARR;
        end
      end else if (rk != 0) begin
        m_busy = 1;
        m_bkey = rk;
        m_next = m_edge + DAS - 1;
      end
      for (int k = 1; k <= 5; k++) comb[k] = m_pend[k] || ev[k];
      if (!m_valid || rdy) begin
        pick = 0;
        for (int i = 0; i < 5; i++) if (pick == 0 && comb[prio[i]]) pick = prio[i];
        m_valid = (pick != 0);
        m_code  = 3'(pick);
        if (pick != 0) comb[pick] = 0;
      end
      for (int k = 1; k <= 5; k++) begin
        m_pend[k] = comb[k];
        m_kp[k]   = held[k];
      end
`ifdef KEY_DEBOUNCE_EN
      // Accept once the last DB+1 samples agree and the last DB edges were out of reset.
      ok = 0;
      if (m_edge >= DB) begin
        ok = 1;
        for (int j = 0; j <= DB; j++) if (hk[(m_edge - j) % 64] != kc) ok = 0;
        for (int j = 0; j < DB; j++)  if (hr[(m_edge - j) % 64]) ok = 0;
      end
      if (ok) m_kcq = kc;
`else
      ok = 0;
`endif
    end
    m_rkc  = kc;
    m_edge = m_edge + 1;
  end

  always @(negedge clk) begin
    if (chk_en) check("model", valid, code, m_valid, m_code);
  end

  typedef struct {
    logic        rst;
    logic [15:0] kc;
    logic        rdy;
    logic        ev;
    logic [2:0]  ec;
  } vec_t;

  vec_t tbl[$];
  int   hold;
  int   k;
  bit   exp_v;
  logic [7:0] codes [7] = '{8'h00, 8'h04, 8'h07, 8'h1A, 8'h16, 8'h2C, 8'h05};

  initial begin
    rst = 1'b1;
    kc  = 16'h0;
    rdy = 1'b1;

    tbl.push_back('{1'b1, 16'h0000, 1'b1, 1'b0, 3'd0});
    tbl.push_back('{1'b1, 16'h0000, 1'b1, 1'b0, 3'd0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0});
`ifndef KEY_DEBOUNCE_EN
    // Single-cycle ROTATE tap
    tbl.push_back('{1'b0, 16'h001A, 1'b1, 1'b0, 3'd0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 3'd3});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0});
    // LEFT and RIGHT together
    tbl.push_back('{1'b0, 16'h0704, 1'b1, 1'b0, 3'd0});
    tbl.push_back('{1'b0, 16'h0704, 1'b1, 1'b1, 3'd1});
    tbl.push_back('{1'b0, 16'h0704, 1'b1, 1'b1, 3'd2});
    tbl.push_back('{1'b0, 16'h0704, 1'b1, 1'b0, 3'd0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0});
    // HARD + ROTATE under back-pressure
    tbl.push_back('{1'b0, 16'h2C1A, 1'b0, 1'b0, 3'd0});
    tbl.push_back('{1'b0, 16'h2C1A, 1'b0, 1'b1, 3'd5});
    tbl.push_back('{1'b0, 16'h2C1A, 1'b0, 1'b1, 3'd5});
    tbl.push_back('{1'b0, 16'h2C1A, 1'b0, 1'b1, 3'd5});
    tbl.push_back('{1'b0, 16'h2C1A, 1'b0, 1'b1, 3'd5});
    tbl.push_back('{1'b0, 16'h2C1A, 1'b1, 1'b1, 3'd3});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0});
`endif

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst;
      kc  = tbl[i].kc;
      rdy = tbl[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), valid, code, tbl[i].ev, tbl[i].ec);
      chk_en = 1;
    end

`ifndef KEY_DEBOUNCE_EN
    // LEFT held 30 cycles: press, then +10, +14, ... until release
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      kc  = (c < 30) ? 16'h0004 : 16'h0000;
      rdy = 1'b1;
      @(posedge clk);
      #1;
      k = c - 1;
      exp_v = (k == 0) || (k >= 10 && k <= 30 && (k - 10) % 4 == 0);
      check("das_arr", valid, code, exp_v, exp_v ? 3'd1 : 3'd0);
    end

    // SOFT held with a one-cycle reset at cycle 12
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      kc  = 16'h0016;
      rst = (c == 12);
      @(posedge clk);
      #1;
      exp_v = (c == 1) || (c == 11) || (c == 13) || (c == 23) || (c == 27);
      check("soft_reset", valid, code, exp_v, exp_v ? 3'd4 : 3'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    kc  = 16'h0000;
`else
    // Short glitch is filtered out
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      kc  = (c < 3) ? 16'h0004 : 16'h0000;
      rdy = 1'b1;
      @(posedge clk);
      #1;
      check("db_glitch", valid, code, 1'b0, 3'd0);
    end
    // Held press appears DB cycles later than unfiltered
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      kc = (c < 8) ? 16'h0004 : 16'h0000;
      @(posedge clk);
      #1;
      exp_v = (c == 6);
      check("db_press", valid, code, exp_v, exp_v ? 3'd1 : 3'd0);
    end
`endif

    // Random traffic against the model
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (hold == 0) begin
        kc   = {codes[$urandom_range(0, 6)], codes[$urandom_range(0, 6)]};
        hold = $urandom_range(1, 24);
      end
      hold = hold - 1;
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    kc  = 16'h0000;
    rdy = 1'b1;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
